mux16_rr_arbiter: RTL and testbench
===================================

Name: mux16_rr_arbiter

Overview:
Round-robin arbiter that shares one 16:1 mux output between 16 requesters.
It drives the 4-bit mux select and a one-hot grant vector.
A grant is held until the owner releases it or a hold-limit preemption occurs.
It sits directly in front of the 16-input mux in the LC-3b datapath and sequences which source owns the mux.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles before preemption when another requester waits; 0 disables preemption.
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk_50  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
req  input  16  level request per requester; held high for the whole transaction.
grant  output  16  one-hot grant, registered; at most one bit set.
select  output  4  binary index of the current/last owner; drives the mux select.
busy  output  1  high while any grant is active (grant != 0).
preempt  output  1  one-cycle pulse on the edge a grant is revoked by the hold limit.

Behaviour:
- One clock, clk_50. Reset is asynchronous and active-high.
- All outputs are registered.
- Reset takes effect immediately, including mid-grant:
  - grant=0, select=0, busy=0, preempt=0.
  - State=IDLE, hold counter=0.
  - Round-robin pointer last=15, so requester 0 has top priority after reset.
- States: IDLE, GRANT.
- IDLE, on a rising edge:
  - If req != 0: pick the first set bit searching last+1, last+2, ... mod 16 (wraps 15->0).
  - Set grant to that one-hot bit, select to its index, busy=1, hold=0, state->GRANT.
  - If req == 0: remain in IDLE; select keeps its last value so the mux does not glitch.
- Request-to-grant latency: request sampled at edge N, grant visible after edge N.
- GRANT, on a rising edge, in priority order:
  1. Owner req low (release): grant=0, busy=0, last=owner, state->IDLE.
  2. MAX_HOLD!=0 and hold==MAX_HOLD-1 and any non-owner req high: grant=0, busy=0, preempt=1 for this cycle only, last=owner, state->IDLE.
     - The owner's req remains pending; it competes again at its lowest rotated priority.
  3. Otherwise: keep the grant.
     - hold increments, saturating at MAX_HOLD-1.
     - If no other requester is waiting, the grant persists indefinitely with no preemption.
- After every release or preemption, busy is low for exactly one cycle (dead cycle) before the next grant can issue.
  - Minimum owner-to-owner turnaround is 2 cycles.
  - Grants never switch on the same edge, so the mux never sees a direct owner swap.
- Non-owner req changes during GRANT do not alter grant or select; they only feed the preemption check.
- An owner dropping req and re-raising it in the same sampled cycle counts as held (level-sampled).
- Invariant: grant == (busy ? 1<<select : 0) every cycle.
- preempt is 0 in every cycle other than the revocation cycle.

Test Plan:
- Reset, then req=16'h0001 -> after next edge grant=16'h0001, select=0, busy=1; drop req -> next edge grant=0, busy=0, select stays 0.
- MAX_HOLD=0; req=16'hFFFF from reset, each owner drops its bit 3 cycles after grant -> grant order 0,1,2,...,15 with one idle cycle between each; re-raise all -> order restarts at 0.
- Wrap: grant 15 and release it, then req=16'h4001 -> grant=16'h0001 (select=0), not requester 14.
- MAX_HOLD=8; req0 held, req5 raised during the grant -> grant 0 lasts 8 cycles, preempt pulses 1 cycle, 1 idle cycle, then grant=16'h0020, select=5; after req5 drops, req0 is regranted.
- MAX_HOLD=8; only req3 held for 50 cycles -> grant=16'h0008 throughout, preempt never asserts.
- Assert reset asynchronously mid-grant -> grant=0, busy=0, select=0 before the next clock edge; release reset, req=16'h0006 -> grant=16'h0002 (pointer was reset to 15).

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
// Round-robin owner sequencer for a shared 16:1 mux. Issues a one-hot grant
// plus the matching binary select, holds the grant until the owner drops its
// request or the hold limit expires while someone else waits, and always
// inserts one idle cycle between owners so the mux never swaps directly.

module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  select,
    output logic        busy,
    output logic        preempt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Last hold count value before preemption is allowed; pinned at 0 when
    // preemption is disabled so the counter never moves.
    localparam int              HOLD_LIM   = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam logic [CNT_W-1:0] HOLD_LIM_C = CNT_W'(HOLD_LIM);
    localparam logic            PREEMPT_EN = (MAX_HOLD != 0);

    state_t             r_state;
    logic [15:0]        r_grant;
    logic [3:0]         r_select;
    logic               r_busy;
    logic               r_preempt;
    logic [3:0]         r_last;
    logic [CNT_W-1:0]   r_hold;

    logic               w_found;
    logic [3:0]         w_pick;
    logic               w_owner_req;
    logic               w_other_req;
    logic               w_hold_limit;

    // Owner request is level-sampled through the current grant mask; every
    // other set request bit counts as a waiting competitor.
    assign w_owner_req  = |(req & r_grant);
    assign w_other_req  = |(req & ~r_grant);
    assign w_hold_limit = PREEMPT_EN && (r_hold == HOLD_LIM_C);

    // Rotating priority search: first set request starting just after the last owner.
    always_comb begin
        logic [3:0] v_idx;
        w_found = 1'b0;
        w_pick  = 4'd0;
        v_idx   = 4'd0;
        for (int i = 1; i <= 16; i++) begin
            v_idx = r_last + 4'(i);
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= 16'h0000;
            r_select  <= 4'd0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_last    <= 4'd15;
            r_hold    <= '0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant  <= 16'h0001 << w_pick;
                        r_select <= w_pick;
                        r_busy   <= 1'b1;
                        r_hold   <= '0;
                        r_state  <= ST_GRANT;
                    end else begin
                        // select deliberately left alone so the mux input does not move
                        r_grant  <= 16'h0000;
                        r_busy   <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req) begin
                        r_grant  <= 16'h0000;
                        r_busy   <= 1'b0;
                        r_last   <= r_select;
                        r_hold   <= '0;
                        r_state  <= ST_IDLE;
                    end else if (w_hold_limit && w_other_req) begin
                        // owner keeps requesting but drops to lowest rotated priority
                        r_grant   <= 16'h0000;
                        r_busy    <= 1'b0;
                        r_preempt <= 1'b1;
                        r_last    <= r_select;
                        r_hold    <= '0;
                        r_state   <= ST_IDLE;
                    end else if (r_hold != HOLD_LIM_C) begin
                        r_hold <= r_hold + CNT_W'(1);
                    end else begin
                        r_hold <= r_hold;
                    end
                end
                default: begin
                    r_grant <= 16'h0000;
                    r_busy  <= 1'b0;
                    r_hold  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant   = r_grant;
    assign select  = r_select;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: instance A uses MAX_HOLD=8, instance B
// uses MAX_HOLD=0. Observed vector is {grant, select, busy, preempt}.

module tb_mux16_rr_arbiter;

    logic        clk_50;
    logic        reset;
    logic [15:0] req_a, req_b;
    logic [15:0] grant_a, grant_b;
    logic [3:0]  select_a, select_b;
    logic        busy_a, busy_b;
    logic        preempt_a, preempt_b;

    logic [21:0] got_a, got_b;
    logic [21:0] exp_v;
    int          n_cmp;
    int          n_err;

    assign got_a = {grant_a, select_a, busy_a, preempt_a};
    assign got_b = {grant_b, select_b, busy_b, preempt_b};

    mux16_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut_a (
        .clk_50  (clk_50),
        .reset   (reset),
        .req     (req_a),
        .grant   (grant_a),
        .select  (select_a),
        .busy    (busy_a),
        .preempt (preempt_a)
    );

    mux16_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) u_dut_b (
        .clk_50  (clk_50),
        .reset   (reset),
        .req     (req_b),
        .grant   (grant_b),
        .select  (select_b),
        .busy    (busy_b),
        .preempt (preempt_b)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_a = 16'h0000;
        req_b = 16'h0000;
        tick();
        tick();
        exp_v = {16'h0000, 4'd0, 1'b0, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL reset_a: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        if (got_b !== exp_v) begin $display("FAIL reset_b: got %h want %h", got_b, exp_v); n_err++; end
        n_cmp++;
        reset = 1'b0;
        tick();
        if (got_a !== exp_v) begin $display("FAIL idle_after_reset_a: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
    endtask

    task automatic test_single();
        req_a = 16'h0001;
        tick();
        exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL single_grant: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        req_a = 16'h0000;
        tick();
        exp_v = {16'h0000, 4'd0, 1'b0, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL single_release: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
    endtask

    task automatic test_rr_order();
        logic [15:0] e_g;
        do_reset();
        req_b = 16'hFFFF;
        tick();
        for (int k = 0; k < 16; k++) begin
            e_g   = 16'h0001 << k;
            exp_v = {e_g, 4'(k), 1'b1, 1'b0};
            if (got_b !== exp_v) begin $display("FAIL rr_grant_%0d: got %h want %h", k, got_b, exp_v); n_err++; end
            n_cmp++;
            tick();
            tick();
            if (got_b !== exp_v) begin $display("FAIL rr_hold_%0d: got %h want %h", k, got_b, exp_v); n_err++; end
            n_cmp++;
            req_b[k] = 1'b0;
            tick();
            exp_v = {16'h0000, 4'(k), 1'b0, 1'b0};
            if (got_b !== exp_v) begin $display("FAIL rr_idle_%0d: got %h want %h", k, got_b, exp_v); n_err++; end
            n_cmp++;
            if (k != 15) tick();
        end
        req_b = 16'hFFFF;
        tick();
        exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
        if (got_b !== exp_v) begin $display("FAIL rr_restart: got %h want %h", got_b, exp_v); n_err++; end
        n_cmp++;
        req_b = 16'h0000;
        tick();
        exp_v = {16'h0000, 4'd0, 1'b0, 1'b0};
        if (got_b !== exp_v) begin $display("FAIL rr_restart_release: got %h want %h", got_b, exp_v); n_err++; end
        n_cmp++;
    endtask

    task automatic test_wrap();
        req_b = 16'h8000;
        tick();
        exp_v = {16'h8000, 4'd15, 1'b1, 1'b0};
        if (got_b !== exp_v) begin $display("FAIL wrap_grant15: got %h want %h", got_b, exp_v); n_err++; end
        n_cmp++;
        req_b = 16'h0000;
        tick();
        exp_v = {16'h0000, 4'd15, 1'b0, 1'b0};
        if (got_b !== exp_v) begin $display("FAIL wrap_release15: got %h want %h", got_b, exp_v); n_err++; end
        n_cmp++;
        req_b = 16'h4001;
        tick();
        exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
        if (got_b !== exp_v) begin $display("FAIL wrap_to_0: got %h want %h", got_b, exp_v); n_err++; end
        n_cmp++;
        req_b = 16'h0000;
        tick();
    endtask

    task automatic test_preempt();
        do_reset();
        req_a = 16'h0001;
        tick();
        for (int c = 1; c <= 8; c++) begin
            exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
            if (got_a !== exp_v) begin $display("FAIL preempt_hold_c%0d: got %h want %h", c, got_a, exp_v); n_err++; end
            n_cmp++;
            if (c == 2) req_a = 16'h0021;
            tick();
        end
        exp_v = {16'h0000, 4'd0, 1'b0, 1'b1};
        if (got_a !== exp_v) begin $display("FAIL preempt_pulse: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        tick();
        exp_v = {16'h0020, 4'd5, 1'b1, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL preempt_next_owner: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        req_a = 16'h0001;
        tick();
        exp_v = {16'h0000, 4'd5, 1'b0, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL preempt_release5: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        tick();
        exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL preempt_regrant0: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        req_a = 16'h0000;
        tick();
    endtask

    task automatic test_no_preempt();
        req_a = 16'h0008;
        tick();
        exp_v = {16'h0008, 4'd3, 1'b1, 1'b0};
        for (int c = 0; c < 50; c++) begin
            if (got_a !== exp_v) begin $display("FAIL solo_hold_c%0d: got %h want %h", c, got_a, exp_v); n_err++; end
            n_cmp++;
            tick();
        end
        req_a = 16'h0000;
        tick();
        exp_v = {16'h0000, 4'd3, 1'b0, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL solo_release: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        // leave the pointer at 1 so a non-reset pointer would pick requester 2
        req_a = 16'h0002;
        tick();
        req_a = 16'h0000;
        tick();
        req_a = 16'h0010;
        tick();
        exp_v = {16'h0010, 4'd4, 1'b1, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL areset_pre_grant: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        #2;
        reset = 1'b1;
        #1;
        exp_v = {16'h0000, 4'd0, 1'b0, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL areset_immediate: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        #1;
        reset = 1'b0;
        req_a = 16'h0006;
        tick();
        exp_v = {16'h0002, 4'd1, 1'b1, 1'b0};
        if (got_a !== exp_v) begin $display("FAIL areset_pointer: got %h want %h", got_a, exp_v); n_err++; end
        n_cmp++;
        req_a = 16'h0000;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        req_a = 16'h0000;
        req_b = 16'h0000;
        test_reset();
        test_single();
        test_rr_order();
        test_wrap();
        test_preempt();
        test_no_preempt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
